// File: rtl/ram_io_responder_pkg.sv
// Shared constants, decode types and sizing helper for the RAM / I/O responder.
package ram_io_responder_pkg;

    // I/O block base address; only bits 17:0 of the CPU address are decoded
    localparam logic [17:0] IO_BASE = 18'h30000;

    // Value of mem_a[17:16] that selects the I/O block
    localparam logic [1:0]  IO_SEL  = 2'b11;

    // Register field mem_a[3:2] inside the I/O block
    localparam logic [1:0]  IO_UART = 2'b00;
    localparam logic [1:0]  IO_CLK  = 2'b01;

    // What the current CPU request targets
    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_RAM,
        ACC_UART,
        ACC_CLK
    } acc_e;

    // Width of a FIFO occupancy counter that must be able to hold 0..depth
    function automatic int tx_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// CPU memory port plus UART side-band signals of the RAM / I/O responder.
interface ram_io_responder_if;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_stop;
    logic        tx_overflow;

    // CPU / UART environment side
    modport master (
        output rdy, mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop,
               program_stop, tx_overflow
    );

    // Responder side
    modport slave (
        input  rdy, mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop,
               program_stop, tx_overflow
    );
endinterface

// File: rtl/ram_io_responder_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. A push while full is dropped
// unless a pop happens in the same cycle, which frees the slot.
module io_tx_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW   = tx_cnt_w(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("io_tx_fifo: DEPTH must be a power of two and at least 4");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped UART and cycle counter behind a CPU port
// that issues one request per cycle and freezes while rdy is low.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_io_responder_if.slave  bus
);

    localparam int             CW     = tx_cnt_w(TX_DEPTH);
    localparam logic [CW-1:0]  AF_LVL = CW'(TX_DEPTH - 2);

    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  io_sel, io_blk;
    logic [1:0]            io_field, io_byte;
    acc_e                  acc;
    logic [7:0]            rd_mux;
    logic                  rd_req, wr_req;

    logic [31:0]           cyc_cnt;
    logic [23:0]           snap_hi;
    logic [7:0]            mem_din_q;
    logic                  stop_q, ovf_q, afull_q;

    logic                  tx_push, tx_acc, tx_pop, tx_full, tx_empty;
    logic [7:0]            tx_din;
    logic [CW-1:0]         tx_count, tx_lvl_nxt;

    logic [13:0]           unused_addr;
    assign unused_addr = bus.mem_a[31:18];

    assign ram_idx  = bus.mem_a[RAM_ADDR_W-1:0];
    assign io_sel   = (bus.mem_a[17:16] == IO_SEL);
    assign io_blk   = io_sel && (bus.mem_a[15:4] == IO_BASE[15:4]);
    assign io_field = bus.mem_a[3:2];
    assign io_byte  = bus.mem_a[1:0];
    assign rd_req   = bus.rdy & ~bus.mem_wr;
    assign wr_req   = bus.rdy &  bus.mem_wr;

    // Classify the request; the UART data register is a single byte address
    always_comb begin
        acc = ACC_NONE;
        if (!io_sel)
            acc = ACC_RAM;
        else if (io_blk && io_field == IO_UART && io_byte == 2'd0)
            acc = ACC_UART;
        else if (io_blk && io_field == IO_CLK)
            acc = ACC_CLK;
    end

    // Read data source; counter byte 0 comes live, upper bytes from snapshot
    always_comb begin
        rd_mux = 8'h00;
        case (acc)
            ACC_RAM:  rd_mux = ram[ram_idx];
            ACC_UART: rd_mux = bus.rx_valid ? bus.rx_data : 8'h00;
            ACC_CLK: begin
                case (io_byte)
                    2'd0:    rd_mux = cyc_cnt[7:0];
                    2'd1:    rd_mux = snap_hi[7:0];
                    2'd2:    rd_mux = snap_hi[15:8];
                    default: rd_mux = snap_hi[23:16];
                endcase
            end
            default:  rd_mux = 8'h00;
        endcase
    end

    // RAM write port: completes in the request cycle, no wait state
    always_ff @(posedge clk) begin
        if (wr_req && acc == ACC_RAM) ram[ram_idx] <= bus.mem_dout;
    end

    // Read data register, cycle counter, snapshot and stop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_din_q <= 8'h00;
            cyc_cnt   <= '0;
            snap_hi   <= '0;
            stop_q    <= 1'b0;
        end else begin
            stop_q <= wr_req && acc == ACC_CLK && io_byte == 2'd0;
            if (bus.rdy) begin
                cyc_cnt <= cyc_cnt + 1'b1;
                if (!bus.mem_wr) mem_din_q <= rd_mux;
                // Only byte 0 snapshots, so a 4-byte read sequence cannot tear
                if (rd_req && acc == ACC_CLK && io_byte == 2'd0)
                    snap_hi <= cyc_cnt[31:8];
            end
        end
    end

    // UART writes: nonzero data byte, or the stop register which sends 0x00
    always_comb begin
        tx_push = 1'b0;
        tx_din  = 8'h00;
        if (wr_req && acc == ACC_UART && bus.mem_dout != 8'h00) begin
            tx_push = 1'b1;
            tx_din  = bus.mem_dout;
        end else if (wr_req && acc == ACC_CLK && io_byte == 2'd0) begin
            tx_push = 1'b1;
        end
    end

    // Drain is independent of rdy
    assign tx_pop = ~tx_empty & bus.tx_ready;
    assign tx_acc = tx_push & (~tx_full | tx_pop);

    // Occupancy after this edge, so back-pressure is early enough for the CPU
    always_comb begin
        tx_lvl_nxt = tx_count;
        case ({tx_acc, tx_pop})
            2'b10:   tx_lvl_nxt = tx_count + 1'b1;
            2'b01:   tx_lvl_nxt = tx_count - 1'b1;
            default: tx_lvl_nxt = tx_count;
        endcase
    end

    // Back-pressure flag and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            afull_q <= (tx_lvl_nxt >= AF_LVL);
            if (tx_push && tx_full && !tx_pop) ovf_q <= 1'b1;
        end
    end

    io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .din   (tx_din),
        .pop   (tx_pop),
        .dout  (bus.tx_data),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Consume pulse in the request cycle so the byte is not read twice
    assign bus.rx_pop         = rst_n & rd_req & (acc == ACC_UART) & bus.rx_valid;
    assign bus.mem_din        = mem_din_q;
    assign bus.tx_valid       = ~tx_empty;
    assign bus.io_buffer_full = afull_q;
    assign bus.program_stop   = stop_q;
    assign bus.tx_overflow    = ovf_q;

endmodule
